// File: rtl/dec_wr_sel.sv
// rtl/dec_wr_sel.sv - registered one-hot write-select decoder with clear sweep
// Outputs are all flops; the clear sweep strobes every register once, then pulses Done.
module dec_wr_sel #(
  parameter int N         = 3,
  parameter int CLR_FIRST = 0
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [N-1:0]        W,
  input  logic                En,
  input  logic                Clr,
  output logic [(1<<N)-1:0]   Y,
  output logic                Zero,
  output logic                Busy,
  output logic                Done,
  output logic                Drop
);

  localparam int M = 1 << N;
  localparam logic [N-1:0] FIRST = N'(CLR_FIRST);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [M-1:0]   y_q, y_d;
  logic           zero_q, zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           drop_q, drop_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
      y_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    y_d     = '0;
    zero_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_d = 1'b1;
        drop_d = En;
        // The index is back at FIRST after the arming cycle (zero_q low) and
        // again once all M strobes have gone out (zero_q high).
        if (zero_q && (idx_q == FIRST)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          y_d[idx_q] = 1'b1;
          zero_d     = 1'b1;
          idx_d      = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (Clr) begin
          state_d = CLEAR;
          idx_d   = FIRST;
          busy_d  = 1'b1;
          drop_d  = En;
        end else if (En) begin
          y_d[W] = 1'b1;
        end
      end
    endcase
  end

  assign Y    = y_q;
  assign Zero = zero_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Drop = drop_q;

endmodule

// File: doc/dec_wr_sel.md
Name: dec_wr_sel

Overview:
Parametrised, registered write-select decoder for the register file. It drives one-hot write strobes (N-to-2^N) to the register array. It adds a sequencer that clears every register in turn, one per cycle, on a single clear request. It sits between the write-address/enable source and the register array, and also drives the array's write-data-zero mux select.

Parameters:
N, 3, address width; output width M = 2**N (derived localparam, not overridable)
CLR_FIRST, 0, index the clear sweep starts from (0..M-1); sweep wraps modulo M and covers all M registers exactly once

Ports:
Clock  in  1  rising-edge clock
Resetn  in  1  asynchronous active-low reset
W  in  N  write address
En  in  1  write enable, sampled each cycle
Clr  in  1  clear request, sampled level; acts only in IDLE
Y  out  M  registered one-hot write strobe (all-zero when no write)
Zero  out  1  registered; high in the same cycle as a clear strobe on Y (selects zero write data)
Busy  out  1  registered; high while the clear sweep is running
Done  out  1  registered one-cycle pulse after the last clear strobe
Drop  out  1  registered one-cycle pulse when an En write is discarded

Behaviour:
- Reset: Resetn is asynchronous and active-low. While Resetn=0: Y=0, Zero=0, Busy=0, Done=0, Drop=0, state=IDLE, sweep counter=CLR_FIRST.
- All outputs are flops. Nothing is combinational from inputs to outputs.
- States: IDLE, CLEAR, DONE.
- IDLE, Clr=0: next Y = En ? (1<<W) : 0. Latency is 1 cycle from sampled W/En to Y. Zero=0, Busy=0.
- IDLE, Clr=1: go to CLEAR. Counter loads CLR_FIRST. Y=0 this edge. Busy=1 from the next cycle.
- IDLE, Clr=1 and En=1 together: clear wins, the write is discarded, and Drop pulses for 1 cycle.
- CLEAR, each cycle: Y = 1<<cnt, Zero=1, Busy=1. The counter increments modulo M (wraps M-1 -> 0).
- CLEAR length: exactly M strobe cycles, each index hit once. After the strobe at index (CLR_FIRST+M-1) mod M, go to DONE.
- CLEAR, En=1: the write is discarded and Drop pulses the following cycle, once per discarded write.
- CLEAR, Clr=1: ignored, no restart.
- DONE: lasts one cycle. Y=0, Zero=0, Busy=0, Done=1. En is honoured normally here (Y follows next cycle). Clr=1 in DONE starts a new sweep. Next state is IDLE, or CLEAR if Clr=1.
- Invariants: popcount(Y) <= 1 always. Zero=1 implies popcount(Y)=1. Busy and Done are never both 1.
- W is an unsigned N-bit value. Every value is legal; there is no out-of-range case.
- Reset mid-sweep: immediate abort, all outputs 0, no Done pulse. The remaining registers are not cleared.
- N=1 is legal (M=2, 2-cycle sweep).

Test Plan:
- Reset/decode, N=3: after Resetn release, W=5,En=1 -> next cycle Y=8'b0010_0000, Zero=0. Then En=0 -> Y=0 next cycle. Sweep all W 0..7 and check one-hot each time.
- Full sweep, N=3, CLR_FIRST=0: Clr pulse in IDLE -> Y=01,02,04,...,80 on 8 consecutive cycles with Zero=1 and Busy=1. Next cycle Done=1, Y=0. Then IDLE.
- Wrap start, CLR_FIRST=6: Clr -> Y order 40,80,01,02,04,08,10,20. Done after 8 strobes.
- Collisions: Clr=1,En=1,W=2 in IDLE -> no strobe at 04 outside the sweep, Drop=1 one cycle. En=1 for 3 cycles mid-sweep -> 3 Drop pulses, sweep order unchanged, Clr held high mid-sweep does not restart.
- Back-to-back: Clr high in DONE cycle -> new sweep starts with no IDLE gap. En=1,W=3 in DONE -> Y=08 next cycle.
- Async reset mid-sweep at the 4th strobe: outputs 0 without waiting for a Clock edge, state IDLE, no Done. Repeat with N=1 and N=5 for parameter coverage (sweep length 2 and 32).
